// File: rtl/qc_pkg.sv
// ---------------------------------------------------------------------------
// qc_pkg
// Shared definitions for the single-qubit gate engine:
//   - default fixed-point format (Q2.14 on 16 bits)
//   - complex amplitude struct
//   - engine state encoding
//   - round-half-up / saturate helper used by the complex dot product
// ---------------------------------------------------------------------------
package qc_pkg;

    localparam int QC_WIDTH = 16;
    localparam int QC_FRAC  = 14;

    typedef struct packed {
        logic signed [QC_WIDTH-1:0] re;
        logic signed [QC_WIDTH-1:0] im;
    } cplx_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        WR0  = 3'd2,
        WR1  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } engine_state_e;

    // Round half up at bit 'frac', arithmetic shift, then clamp to a signed
    // 'width'-bit range. The accumulator is carried in 64 bits so any
    // WIDTH up to 30 fits without overflow.
    function automatic logic signed [63:0] round_sat(
        input logic signed [63:0] acc,
        input int                 frac,
        input int                 width
    );
        logic signed [63:0] rnd;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        rnd = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi  = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (width - 1));
        if (rnd > hi) begin
            round_sat = hi;
        end else if (rnd < lo) begin
            round_sat = lo;
        end else begin
            round_sat = rnd;
        end
    endfunction

endpackage

// File: rtl/cplx_dot2.sv
// ---------------------------------------------------------------------------
// cplx_dot2
// Combinational complex dot product y = c0*x0 + c1*x1 with round-half-up
// at FRAC and saturation to WIDTH bits.
// Ports:
//   c0_r/c0_i, c1_r/c1_i : coefficients, signed Q(FRAC)
//   x0_r/x0_i, x1_r/x1_i : operands, signed Q(FRAC)
//   y_r/y_i              : rounded, saturated result
// ---------------------------------------------------------------------------
module cplx_dot2
    import qc_pkg::*;
#(
    parameter int WIDTH = QC_WIDTH,
    parameter int FRAC  = QC_FRAC
) (
    input  logic signed [WIDTH-1:0] c0_r,
    input  logic signed [WIDTH-1:0] c0_i,
    input  logic signed [WIDTH-1:0] x0_r,
    input  logic signed [WIDTH-1:0] x0_i,
    input  logic signed [WIDTH-1:0] c1_r,
    input  logic signed [WIDTH-1:0] c1_i,
    input  logic signed [WIDTH-1:0] x1_r,
    input  logic signed [WIDTH-1:0] x1_i,
    output logic signed [WIDTH-1:0] y_r,
    output logic signed [WIDTH-1:0] y_i
);

    localparam int PW = 2 * WIDTH;      // full product width
    localparam int AW = 2 * WIDTH + 2;  // four-product sum never overflows

    logic signed [PW-1:0] p_rr0, p_ii0, p_ri0, p_ir0;
    logic signed [PW-1:0] p_rr1, p_ii1, p_ri1, p_ir1;
    logic signed [AW-1:0] acc_r, acc_i;

    // Full-precision partial products, sign-extended before multiplying
    assign p_rr0 = PW'(c0_r) * PW'(x0_r);
    assign p_ii0 = PW'(c0_i) * PW'(x0_i);
    assign p_ri0 = PW'(c0_r) * PW'(x0_i);
    assign p_ir0 = PW'(c0_i) * PW'(x0_r);
    assign p_rr1 = PW'(c1_r) * PW'(x1_r);
    assign p_ii1 = PW'(c1_i) * PW'(x1_i);
    assign p_ri1 = PW'(c1_r) * PW'(x1_i);
    assign p_ir1 = PW'(c1_i) * PW'(x1_r);

    // (a+bi)(c+di): real = ac - bd, imag = ad + bc
    assign acc_r = AW'(p_rr0) - AW'(p_ii0) + AW'(p_rr1) - AW'(p_ii1);
    assign acc_i = AW'(p_ri0) + AW'(p_ir0) + AW'(p_ri1) + AW'(p_ir1);

    assign y_r = WIDTH'(round_sat(64'(acc_r), FRAC, WIDTH));
    assign y_i = WIDTH'(round_sat(64'(acc_i), FRAC, WIDTH));

endmodule

// File: rtl/gate_apply_engine.sv
// ---------------------------------------------------------------------------
// gate_apply_engine
// Applies a latched 2x2 complex unitary to every amplitude pair of a
// 2^N_QUBITS state vector that differs only in the target bit, writing both
// results back in place. Three cycles per pair: READ, WR0 (write i0),
// WR1 (write i1).
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   start, target          : gate request (sampled only in IDLE) and qubit
//   u00..u11 (_r/_i)       : signed Q(FRAC) gate coefficients
//   busy, done, err        : status; done/err are one-cycle pulses
//   mem_we, mem_addr_a/b   : memory control (port A read/write, B read)
//   mem_din_a_r/_i         : write data for port A
//   mem_dout_a/b (_r/_i)   : combinational read data
// The target port is one bit wider than needed for valid indices so that
// out-of-range requests can be expressed and rejected with err.
// ---------------------------------------------------------------------------
module gate_apply_engine
    import qc_pkg::*;
#(
    parameter  int N_QUBITS = 4,
    parameter  int WIDTH    = QC_WIDTH,
    parameter  int FRAC     = QC_FRAC,
    localparam int TW       = $clog2(N_QUBITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [TW-1:0]           target,
    input  logic signed [WIDTH-1:0] u00_r,
    input  logic signed [WIDTH-1:0] u00_i,
    input  logic signed [WIDTH-1:0] u01_r,
    input  logic signed [WIDTH-1:0] u01_i,
    input  logic signed [WIDTH-1:0] u10_r,
    input  logic signed [WIDTH-1:0] u10_i,
    input  logic signed [WIDTH-1:0] u11_r,
    input  logic signed [WIDTH-1:0] u11_i,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    mem_we,
    output logic [N_QUBITS-1:0]     mem_addr_a,
    output logic [N_QUBITS-1:0]     mem_addr_b,
    output logic signed [WIDTH-1:0] mem_din_a_r,
    output logic signed [WIDTH-1:0] mem_din_a_i,
    input  logic signed [WIDTH-1:0] mem_dout_a_r,
    input  logic signed [WIDTH-1:0] mem_dout_a_i,
    input  logic signed [WIDTH-1:0] mem_dout_b_r,
    input  logic signed [WIDTH-1:0] mem_dout_b_i
);

    localparam int                   PW     = (N_QUBITS > 1) ? N_QUBITS - 1 : 1;
    localparam logic [PW-1:0]        LAST_P = PW'((1 << (N_QUBITS - 1)) - 1);
    localparam logic [TW-1:0]        N_LIM  = TW'(N_QUBITS);
    localparam logic [N_QUBITS-1:0]  ONE_N  = N_QUBITS'(1);

    engine_state_e           state_q, state_d;
    logic [PW-1:0]           p_q, p_d;
    logic [TW-1:0]           t_q, t_d;
    // Coefficient order: 00r,00i,01r,01i,10r,10i,11r,11i
    logic [7:0][WIDTH-1:0]   u_q, u_d;
    logic signed [WIDTH-1:0] a0_r_q, a0_i_q, a1_r_q, a1_i_q;
    logic signed [WIDTH-1:0] a0_r_d, a0_i_d, a1_r_d, a1_i_d;
    logic signed [WIDTH-1:0] n1_r_q, n1_i_q, n1_r_d, n1_i_d;
    logic signed [WIDTH-1:0] n0_r_s, n0_i_s, n1_r_s, n1_i_s;

    logic                    busy_q, done_q, err_q, we_q;
    logic                    busy_d, done_d, err_d, we_d;
    logic [N_QUBITS-1:0]     addr_a_q, addr_b_q, addr_a_d, addr_b_d;

    logic [N_QUBITS-1:0]     p_ext_s, low_mask_s, i0_s, i1_s;

    cplx_dot2 #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dot_n0 (
        .c0_r(u_q[0]), .c0_i(u_q[1]), .x0_r(a0_r_q), .x0_i(a0_i_q),
        .c1_r(u_q[2]), .c1_i(u_q[3]), .x1_r(a1_r_q), .x1_i(a1_i_q),
        .y_r (n0_r_s), .y_i (n0_i_s)
    );

    cplx_dot2 #(.WIDTH(WIDTH), .FRAC(FRAC)) u_dot_n1 (
        .c0_r(u_q[4]), .c0_i(u_q[5]), .x0_r(a0_r_q), .x0_i(a0_i_q),
        .c1_r(u_q[6]), .c1_i(u_q[7]), .x1_r(a1_r_q), .x1_i(a1_i_q),
        .y_r (n1_r_s), .y_i (n1_i_s)
    );

    // Pair indices for the next cycle: bits of p below t stay, bits at and
    // above t move up one place, leaving a 0 (i0) or 1 (i1) at bit t.
    always_comb begin
        p_ext_s    = N_QUBITS'(p_d);
        low_mask_s = (ONE_N << t_d) - ONE_N;
        i0_s       = ((p_ext_s & ~low_mask_s) << 1) | (p_ext_s & low_mask_s);
        i1_s       = i0_s | (ONE_N << t_d);
    end

    // Next-state and datapath register update
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        t_d     = t_q;
        u_d     = u_q;
        a0_r_d  = a0_r_q;
        a0_i_d  = a0_i_q;
        a1_r_d  = a1_r_q;
        a1_i_d  = a1_i_q;
        n1_r_d  = n1_r_q;
        n1_i_d  = n1_i_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (target < N_LIM) begin
                        state_d = READ;
                        t_d     = target;
                        p_d     = '0;
                        u_d     = {u11_i, u11_r, u10_i, u10_r,
                                   u01_i, u01_r, u00_i, u00_r};
                    end else begin
                        state_d = ERR;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                a0_r_d  = mem_dout_a_r;
                a0_i_d  = mem_dout_a_i;
                a1_r_d  = mem_dout_b_r;
                a1_i_d  = mem_dout_b_i;
                state_d = WR0;
            end
            WR0: begin
                n1_r_d  = n1_r_s;
                n1_i_d  = n1_i_s;
                state_d = WR1;
            end
            WR1: begin
                if (p_q == LAST_P) begin
                    state_d = DONE;
                end else begin
                    p_d     = p_q + PW'(1);
                    state_d = READ;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered control outputs, decoded from the state being entered
    always_comb begin
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        we_d     = 1'b0;
        addr_a_d = '0;
        addr_b_d = '0;
        case (state_d)
            READ: begin
                busy_d   = 1'b1;
                addr_a_d = i0_s;
                addr_b_d = i1_s;
            end
            WR0: begin
                busy_d   = 1'b1;
                we_d     = 1'b1;
                addr_a_d = i0_s;
                addr_b_d = i1_s;
            end
            WR1: begin
                busy_d   = 1'b1;
                we_d     = 1'b1;
                addr_a_d = i1_s;
                addr_b_d = i1_s;
            end
            DONE: done_d = 1'b1;
            ERR: begin
                done_d = 1'b1;
                err_d  = 1'b1;
            end
            default: busy_d = 1'b0;
        endcase
    end

    // Write data: n0 straight from the registered operands in WR0, the
    // held n1 in WR1, zero otherwise
    always_comb begin
        mem_din_a_r = '0;
        mem_din_a_i = '0;
        case (state_q)
            WR0: begin
                mem_din_a_r = n0_r_s;
                mem_din_a_i = n0_i_s;
            end
            WR1: begin
                mem_din_a_r = n1_r_q;
                mem_din_a_i = n1_i_q;
            end
            default: begin
                mem_din_a_r = '0;
                mem_din_a_i = '0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            p_q      <= '0;
            t_q      <= '0;
            u_q      <= '0;
            a0_r_q   <= '0;
            a0_i_q   <= '0;
            a1_r_q   <= '0;
            a1_i_q   <= '0;
            n1_r_q   <= '0;
            n1_i_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            t_q      <= t_d;
            u_q      <= u_d;
            a0_r_q   <= a0_r_d;
            a0_i_q   <= a0_i_d;
            a1_r_q   <= a1_r_d;
            a1_i_q   <= a1_i_d;
            n1_r_q   <= n1_r_d;
            n1_i_q   <= n1_i_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            we_q     <= we_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign mem_we     = we_q;
    assign mem_addr_a = addr_a_q;
    assign mem_addr_b = addr_b_q;

endmodule

// File: tb/tb_gate_apply_engine.sv
// ---------------------------------------------------------------------------
// tb_gate_apply_engine
// Randomised self-checking bench. The bench owns the state memory; a
// reference model predicts, for each accepted gate, the per-cycle output
// schedule and the written values, and one compare process checks every
// cycle against it while mirroring the expected writes into a model memory.
// ---------------------------------------------------------------------------
module tb_gate_apply_engine;
    import qc_pkg::*;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int F     = 14;
    localparam int TW    = 3;
    localparam int DEPTH = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [TW-1:0]       target;
    logic signed [W-1:0] u00_r, u00_i, u01_r, u01_i, u10_r, u10_i, u11_r, u11_i;
    logic                busy, done, err, mem_we;
    logic [N-1:0]        mem_addr_a, mem_addr_b;
    logic signed [W-1:0] mem_din_a_r, mem_din_a_i;
    logic signed [W-1:0] mem_dout_a_r, mem_dout_a_i, mem_dout_b_r, mem_dout_b_i;

    gate_apply_engine #(.N_QUBITS(N), .WIDTH(W), .FRAC(F)) dut (
        .clk(clk), .rst(rst), .start(start), .target(target),
        .u00_r(u00_r), .u00_i(u00_i), .u01_r(u01_r), .u01_i(u01_i),
        .u10_r(u10_r), .u10_i(u10_i), .u11_r(u11_r), .u11_i(u11_i),
        .busy(busy), .done(done), .err(err), .mem_we(mem_we),
        .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .mem_din_a_r(mem_din_a_r), .mem_din_a_i(mem_din_a_i),
        .mem_dout_a_r(mem_dout_a_r), .mem_dout_a_i(mem_dout_a_i),
        .mem_dout_b_r(mem_dout_b_r), .mem_dout_b_i(mem_dout_b_i)
    );

    always #5 clk = ~clk;

    // ---------------- state memory (combinational read, registered write)
    logic signed [W-1:0] mem_r [DEPTH];
    logic signed [W-1:0] mem_i [DEPTH];
    logic                ld_en;
    logic [N-1:0]        ld_addr;
    logic signed [W-1:0] ld_r, ld_i;

    always @(posedge clk) begin
        if (ld_en) begin
            mem_r[ld_addr] <= ld_r;
            mem_i[ld_addr] <= ld_i;
        end else if (mem_we) begin
            mem_r[mem_addr_a] <= mem_din_a_r;
            mem_i[mem_addr_a] <= mem_din_a_i;
        end
    end

    assign mem_dout_a_r = mem_r[mem_addr_a];
    assign mem_dout_a_i = mem_i[mem_addr_a];
    assign mem_dout_b_r = mem_r[mem_addr_b];
    assign mem_dout_b_i = mem_i[mem_addr_b];

    // ---------------- checking infrastructure
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model
    typedef struct {
        bit           busy;
        bit           done;
        bit           err;
        bit           we;
        bit           chk_addr;
        logic [N-1:0] a;
        logic [N-1:0] b;
        cplx_t        d;
    } rec_t;

    rec_t  exp_q[$];
    cplx_t exp_mem [DEPTH];
    cplx_t cu [4];   // u00, u01, u10, u11
    bit    chk_en = 1'b0;

    function automatic logic signed [W-1:0] rnd_sat(input longint acc);
        longint v;
        v = (acc + (longint'(1) << (F - 1))) >>> F;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return W'(v);
    endfunction

    function automatic cplx_t cmac(input cplx_t c0, input cplx_t x0,
                                   input cplx_t c1, input cplx_t x1);
        cplx_t  y;
        longint re, im;
        re = longint'(c0.re) * longint'(x0.re) - longint'(c0.im) * longint'(x0.im)
           + longint'(c1.re) * longint'(x1.re) - longint'(c1.im) * longint'(x1.im);
        im = longint'(c0.re) * longint'(x0.im) + longint'(c0.im) * longint'(x0.re)
           + longint'(c1.re) * longint'(x1.im) + longint'(c1.im) * longint'(x1.re);
        y.re = rnd_sat(re);
        y.im = rnd_sat(im);
        return y;
    endfunction

    function automatic rec_t mk(input bit b, input bit dn, input bit e, input bit we,
                                input int a, input int bb, input cplx_t d);
        rec_t r;
        r.busy = b; r.done = dn; r.err = e; r.we = we;
        r.chk_addr = b;
        r.a = N'(a); r.b = N'(bb); r.d = d;
        return r;
    endfunction

    // One comparison pass per cycle, sampled 2 time units after the edge
    rec_t cur;
    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else cur = mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, '0);
            check("busy", busy, cur.busy);
            check("done", done, cur.done);
            check("err", err, cur.err);
            check("mem_we", mem_we, cur.we);
            if (cur.chk_addr) begin
                check("addr_a", mem_addr_a, cur.a);
                check("addr_b", mem_addr_b, cur.b);
            end
            if (cur.we) begin
                check("din_r", mem_din_a_r, cur.d.re);
                check("din_i", mem_din_a_i, cur.d.im);
                exp_mem[cur.a] = cur.d;
            end
        end
    end

    // ---------------- stimulus helpers
    task automatic poke(input int a, input cplx_t v);
        ld_en = 1'b1; ld_addr = N'(a); ld_r = v.re; ld_i = v.im;
        exp_mem[a] = v;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic fill_zero();
        for (int i = 0; i < DEPTH; i++) poke(i, '0);
    endtask

    task automatic fill_rand(input int span);
        cplx_t v;
        for (int i = 0; i < DEPTH; i++) begin
            v.re = W'($signed($urandom_range(0, 2 * span)) - span);
            v.im = W'($signed($urandom_range(0, 2 * span)) - span);
            poke(i, v);
        end
    endtask

    task automatic mem_check(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            check({tag, "_mem_re"}, mem_r[i], exp_mem[i].re);
            check({tag, "_mem_im"}, mem_i[i], exp_mem[i].im);
        end
    endtask

    int r_busy, r_we, r_done, r_err;

    // Issue one gate request with cu[] and run it out, optionally pulsing
    // reset in a given cycle after acceptance. Counts busy/we cycles and
    // records the first done/err cycle (1 = cycle after the start edge).
    task automatic launch(input int t, input int rst_at);
        int   lim;
        start = 1'b1; target = TW'(t);
        u00_r = cu[0].re; u00_i = cu[0].im; u01_r = cu[1].re; u01_i = cu[1].im;
        u10_r = cu[2].re; u10_i = cu[2].im; u11_r = cu[3].re; u11_i = cu[3].im;
        if (t < N) begin
            for (int p = 0; p < DEPTH / 2; p++) begin
                int    i0, i1;
                cplx_t n0, n1;
                i0 = (p / (1 << t)) * (1 << (t + 1)) + (p % (1 << t));
                i1 = i0 + (1 << t);
                n0 = cmac(cu[0], exp_mem[i0], cu[1], exp_mem[i1]);
                n1 = cmac(cu[2], exp_mem[i0], cu[3], exp_mem[i1]);
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, i0, i1, '0));
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, i0, i1, n0));
                exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, i1, i1, n1));
            end
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, '0));
            lim = 28;
        end else begin
            exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, '0));
            lim = 4;
        end
        r_busy = 0; r_we = 0; r_done = 0; r_err = 0;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            if (busy === 1'b1) r_busy++;
            if (mem_we === 1'b1) r_we++;
            if (done === 1'b1 && r_done == 0) r_done = c;
            if (err === 1'b1 && r_err == 0) r_err = c;
            if (rst_at != 0 && c == rst_at + 1) begin
                rst = 1'b0;
                check("rst_busy_low", busy, 1'b0);
                check("rst_we_low", mem_we, 1'b0);
            end
            // Noise on inputs the engine must ignore while a gate runs
            start  = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            target = TW'($urandom);
            {u00_r, u00_i, u01_r, u01_i} = {$urandom, $urandom};
            {u10_r, u10_i, u11_r, u11_i} = {$urandom, $urandom};
            if (rst_at != 0 && c == rst_at) begin
                rst   = 1'b1;
                start = 1'b0;
                exp_q.delete();
            end
        end
        start = 1'b0;
    endtask

    task automatic rand_coeffs();
        for (int k = 0; k < 4; k++) begin
            cu[k].re = W'($urandom);
            cu[k].im = W'($urandom);
        end
    endtask

    // ---------------- main sequence
    logic signed [W-1:0] snap_r [DEPTH];
    logic signed [W-1:0] snap_i [DEPTH];

    initial begin
        rst = 1'b1; start = 1'b0; target = '0; ld_en = 1'b0; ld_addr = '0;
        ld_r = '0; ld_i = '0;
        u00_r = '0; u00_i = '0; u01_r = '0; u01_i = '0;
        u10_r = '0; u10_i = '0; u11_r = '0; u11_i = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr_a", mem_addr_a, 0);
        check("rst_addr_b", mem_addr_b, 0);
        check("rst_din_r", mem_din_a_r, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Pauli-X on qubit 0
        fill_zero();
        poke(0, '{re: 16'sd16384, im: 16'sd0});
        cu[0] = '0; cu[3] = '0;
        cu[1] = '{re: 16'sd16384, im: 16'sd0};
        cu[2] = '{re: 16'sd16384, im: 16'sd0};
        launch(0, 0);
        check("x_busy_cycles", r_busy, 24);
        check("x_done_cycle", r_done, 25);
        check("x_we_cycles", r_we, 16);
        check("x_mem1", mem_r[1], 16384);
        check("x_mem0", mem_r[0], 0);
        mem_check("x");

        // Hadamard on qubit 3
        fill_zero();
        poke(0, '{re: 16'sd16384, im: 16'sd0});
        cu[0] = '{re: 16'sd11585, im: 16'sd0};
        cu[1] = '{re: 16'sd11585, im: 16'sd0};
        cu[2] = '{re: 16'sd11585, im: 16'sd0};
        cu[3] = '{re: -16'sd11585, im: 16'sd0};
        launch(3, 0);
        check("h_mem0", mem_r[0], 11585);
        check("h_mem8", mem_r[8], 11585);
        check("h_mem8_im", mem_i[8], 0);
        check("h_mem1", mem_r[1], 0);
        mem_check("h");

        // Identity on qubit 2: memory must come back bit-exact
        fill_rand(8000);
        for (int i = 0; i < DEPTH; i++) begin
            snap_r[i] = exp_mem[i].re;
            snap_i[i] = exp_mem[i].im;
        end
        cu[0] = '{re: 16'sd16384, im: 16'sd0};
        cu[1] = '0; cu[2] = '0;
        cu[3] = '{re: 16'sd16384, im: 16'sd0};
        launch(2, 0);
        check("id_we_cycles", r_we, 16);
        for (int i = 0; i < DEPTH; i++) begin
            check("id_same_re", mem_r[i], snap_r[i]);
            check("id_same_im", mem_i[i], snap_i[i]);
        end

        // Saturation, positive then negative
        fill_zero();
        poke(0, '{re: 16'sd32767, im: 16'sd0});
        poke(1, '{re: 16'sd32767, im: 16'sd0});
        cu[0] = '{re: 16'sd32767, im: 16'sd0};
        cu[1] = '{re: 16'sd32767, im: 16'sd0};
        cu[2] = '0; cu[3] = '0;
        launch(0, 0);
        check("sat_pos", mem_r[0], 32767);
        mem_check("sat_pos");
        poke(0, '{re: -16'sd32768, im: 16'sd0});
        poke(1, '{re: -16'sd32768, im: 16'sd0});
        launch(0, 0);
        check("sat_neg", mem_r[0], -32768);
        mem_check("sat_neg");

        // Out-of-range target
        fill_rand(8000);
        rand_coeffs();
        launch(4, 0);
        check("err_busy_cycles", r_busy, 0);
        check("err_done_cycle", r_done, 1);
        check("err_err_cycle", r_err, 1);
        check("err_we_cycles", r_we, 0);
        mem_check("err");

        // Reset in cycle k+5 (WR0 of the second pair), then a clean gate
        rand_coeffs();
        launch(1, 5);
        check("rst_mid_done", r_done, 0);
        check("rst_mid_busy_cycles", r_busy, 5);
        check("rst_mid_we_cycles", r_we, 3);
        mem_check("rst_mid");
        rand_coeffs();
        launch(1, 0);
        check("after_rst_done_cycle", r_done, 25);
        mem_check("after_rst");

        // Random gates, targets including out-of-range values
        for (int it = 0; it < 10; it++) begin
            int t;
            fill_rand(20000);
            rand_coeffs();
            t = $urandom_range(0, 7);
            launch(t, 0);
            check("rnd_done_cycle", r_done, (t < N) ? 25 : 1);
            mem_check("rnd");
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
